// File: rtl/moving_average_inverse.sv
// Inverse of the 3-tap moving averager: rebuilds x[n] from Z[n] by scaled reciprocal minus history.
// Optional saturation counter output sat_cnt is built when MA_INV_SATCNT_EN is defined.
module moving_average_inverse #(
  parameter int DATA_W     = 8,
  parameter int INV_GAIN   = 49,
  parameter int GAIN_SHIFT = 4,
  parameter int WARMUP     = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     enable_n,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] Z,
  output logic signed [DATA_W-1:0] X_hat,
  output logic                     out_valid,
  output logic                     sat
`ifdef MA_INV_SATCNT_EN
  ,
  output logic [7:0]               sat_cnt
`endif
);

  // Handshake: a sample is accepted on a rising Clk edge with enable_n=0 and clr=0;
  // results appear on that same edge, out_valid pulses for one cycle per accept.

  localparam int PW = DATA_W + 8;
  localparam logic signed [PW-1:0] GAIN  = PW'(INV_GAIN);
  localparam logic signed [PW-1:0] MAX_V = PW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] MIN_V = -PW'(1 << (DATA_W - 1));
  localparam logic [1:0]           WARM  = 2'(WARMUP);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                    state;
  logic [1:0]                cnt;
  logic signed [DATA_W-1:0]  h1, h2;
  logic signed [PW-1:0]      z_ext, h1_ext, h2_ext;
  logic signed [PW-1:0]      prod, scl, sum;
  logic signed [DATA_W-1:0]  clip;
  logic                      clip_hit;
  logic                      accept;

  assign accept = !enable_n && !clr;
  assign z_ext  = $signed({{(PW-DATA_W){Z[DATA_W-1]}}, Z});
  assign h1_ext = $signed({{(PW-DATA_W){h1[DATA_W-1]}}, h1});
  assign h2_ext = $signed({{(PW-DATA_W){h2[DATA_W-1]}}, h2});
  assign prod   = z_ext * GAIN;
  assign scl    = prod >>> GAIN_SHIFT;
  // Difference is held at product width so it cannot wrap before clipping.
  assign sum    = scl - h1_ext - h2_ext;

  always_comb begin
    clip     = sum[DATA_W-1:0];
    clip_hit = 1'b0;
    if (sum > MAX_V) begin
      clip     = MAX_V[DATA_W-1:0];
      clip_hit = 1'b1;
    end else if (sum < MIN_V) begin
      clip     = MIN_V[DATA_W-1:0];
      clip_hit = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      h1        <= '0;
      h2        <= '0;
      X_hat     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
`ifdef MA_INV_SATCNT_EN
      sat_cnt   <= '0;
`endif
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      h1        <= '0;
      h2        <= '0;
      X_hat     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
`ifdef MA_INV_SATCNT_EN
      sat_cnt   <= '0;
`endif
    end else if (accept) begin
      X_hat     <= clip;
      sat       <= clip_hit;
      h2        <= h1;
      h1        <= clip;
      out_valid <= (state == RUN);
`ifdef MA_INV_SATCNT_EN
      if (clip_hit && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
`endif
      case (state)
        IDLE: begin
          cnt   <= 2'd1;
          state <= (WARM <= 2'd1) ? RUN : PRIME;
        end
        PRIME: begin
          cnt <= cnt + 2'd1;
          if (cnt + 2'd1 == WARM) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end else begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average_inverse.sv
// Directed bench for moving_average_inverse: vector table plus an enable-toggle/async-reset sequence.
// Checks sat_cnt as well when MA_INV_SATCNT_EN is defined.
module tb_moving_average_inverse;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       enable_n = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] Z = '0;
  logic [7:0] X_hat;
  logic       out_valid;
  logic       sat;
`ifdef MA_INV_SATCNT_EN
  logic [7:0] sat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  moving_average_inverse dut (
    .Clk(Clk),
    .Reset(Reset),
    .enable_n(enable_n),
    .clr(clr),
    .Z(Z),
    .X_hat(X_hat),
    .out_valid(out_valid),
    .sat(sat)
`ifdef MA_INV_SATCNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       en_n;
    logic [7:0] z;
    logic [7:0] x;
    logic       v;
    logic       s;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[30];

  task automatic step(input logic r, input logic c, input logic e, input logic [7:0] z);
    Reset    = r;
    clr      = c;
    enable_n = e;
    Z        = z;
    @(posedge Clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] x, input logic v, input logic s);
    check8({tag, " X_hat"}, X_hat, x);
    check1({tag, " out_valid"}, out_valid, v);
    check1({tag, " sat"}, sat, s);
  endtask

  // Z = 10, 20, 30 from a clean start gives 30, 31, 30; toggling enable_n between accepts.
  task automatic toggle_pass(input string tag);
    logic [7:0] zt[3];
    logic [7:0] xt[3];
    logic       vt[3];
    zt = '{8'd10, 8'd20, 8'd30};
    xt = '{8'd30, 8'd31, 8'd30};
    vt = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, zt[i]);
      check_out($sformatf("%s acc%0d", tag, i), xt[i], vt[i], 1'b0);
      if (i < 2) begin
        step(1'b0, 1'b0, 1'b1, 8'd77);
        check_out($sformatf("%s hold%0d", tag, i), xt[i], 1'b0, 1'b0);
      end
    end
    // Async reset between edges must clear outputs without waiting for Clk.
    #2;
    Reset = 1'b1;
    #1;
    check_out({tag, " async_rst"}, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'd0);
  endtask

  initial begin
    //           rst   clr   en_n  z       x       v     s     cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 8'd0};
    for (int i = 1; i <= 6; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, (i >= 3), 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd64,  1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd0,   1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd0,   1'b1, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'hFF,  8'hFC,  1'b0, 1'b0, 8'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 8'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h7F,  8'h7F,  1'b0, 1'b1, 8'd1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h80,  8'h80,  1'b0, 1'b1, 8'd2};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 8'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd64,  1'b0, 1'b0, 8'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd0,   1'b0, 1'b0, 8'd0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd0,   1'b1, 1'b0, 8'd0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 8'd50,  8'd0,   1'b0, 1'b0, 8'd0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd64,  1'b0, 1'b0, 8'd0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 8'd99,  8'd64,  1'b0, 1'b0, 8'd0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd0,   1'b0, 1'b0, 8'd0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 8'd21,  8'd0,   1'b1, 1'b0, 8'd0};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 8'd10,  8'd30,  1'b1, 1'b0, 8'd0};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 8'hEC,  8'hA4,  1'b1, 1'b0, 8'd0};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 8'd40,  8'h7F,  1'b1, 1'b1, 8'd1};
    vecs[29] = '{1'b0, 1'b0, 1'b1, 8'd40,  8'h7F,  1'b0, 1'b0, 8'd1};

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].en_n, vecs[i].z);
      check_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].v, vecs[i].s);
`ifdef MA_INV_SATCNT_EN
      check8($sformatf("vec%0d sat_cnt", i), sat_cnt, vecs[i].cnt);
`endif
    end

    step(1'b1, 1'b0, 1'b1, 8'd0);
    toggle_pass("tog_a");
    toggle_pass("tog_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
